// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM encoding,
// grant id width and the per-channel weight slice position.
package wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic int id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int weight_lsb(input int ch, input int weight_w);
    return ch * weight_w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Arbiter-facing bundle: per-channel weights and FIFO flags in, read strobes
// and grant status out. The arbiter uses the slave modport.
interface wrr_arbiter_if #(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 3
);
  localparam int ID_W = wrr_pkg::id_width(NUM_CH);

  logic [NUM_CH*WEIGHT_W-1:0] weight;
  logic [NUM_CH-1:0]          empty;
  logic                       ready;
  logic [NUM_CH-1:0]          pop;
  logic [ID_W-1:0]            grant_id;
  logic                       grant_valid;

  modport master (
    output weight, empty, ready,
    input  pop, grant_id, grant_valid
  );

  modport slave (
    input  weight, empty, ready,
    output pop, grant_id, grant_valid
  );
endinterface

// File: rtl/wrr_arbiter_rr_pick.sv
// Cyclic priority encoder: first eligible channel at or after start,
// wrapping from NUM_CH-1 back to 0.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [ID_W-1:0]   start,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  // Scan farthest offset first so the closest eligible channel wins.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (eligible[c]) begin
        found = 1'b1;
        idx   = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter draining NUM_CH FIFOs into one downstream port;
// each turn pops up to the channel's weight, with no bubble between turns.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  wrr_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_CH);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   pop_d;
  logic [ID_W-1:0]     pick_start;
  logic [ID_W-1:0]     next_ptr;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [WEIGHT_W-1:0] pick_weight;
  logic                turn_end;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = !bus.empty[i] && (bus.weight[weight_lsb(i, WEIGHT_W) +: WEIGHT_W] != '0);
    end
  end

  assign next_ptr    = (grant_id_q == ID_W'(NUM_CH - 1)) ? '0 : grant_id_q + 1'b1;
  assign pick_start  = (state_q == SERVE) ? next_ptr : ptr_q;
  assign pick_weight = bus.weight[weight_lsb(int'(pick_idx), WEIGHT_W) +: WEIGHT_W];

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    credit_d   = credit_q;
    pop_d      = '0;
    turn_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = SERVE;
          grant_id_d = pick_idx;
          credit_d   = pick_weight;
        end
      end
      SERVE: begin
        // An empty granted FIFO forfeits the rest of its quantum without popping.
        if (bus.empty[grant_id_q]) begin
          turn_end = 1'b1;
        end else if (bus.ready) begin
          pop_d[grant_id_q] = !reset;
          credit_d          = credit_q - 1'b1;
          turn_end          = (credit_q == WEIGHT_W'(1));
        end
        if (turn_end) begin
          ptr_d = next_ptr;
          if (pick_found) begin
            grant_id_d = pick_idx;
            credit_d   = pick_weight;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      credit_q   <= credit_d;
    end
  end

  assign bus.pop         = pop_d;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = (state_q == SERVE);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: a turn-level reference model predicts each
// cycle's pop/grant outputs, and a monitor compares them at the falling edge.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 3;

  typedef struct {
    int pop;
    int gv;
    int gid;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wrr_arbiter_if #(.NUM_CH(N), .WEIGHT_W(WW)) bus ();

  wrr_arbiter #(.NUM_CH(N), .WEIGHT_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   seen[$];
  logic collect = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  // Model state: the channel whose turn is running (-1 when idle), words left
  // in its quantum, where the next search starts, and the last granted id.
  int m_cur  = -1;
  int m_left = 0;
  int m_ptr  = 0;
  int m_gid  = 0;

  localparam logic [N*WW-1:0] W1234 = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [N*WW-1:0] W2222 = {3'd2, 3'd2, 3'd2, 3'd2};
  localparam logic [N*WW-1:0] W3333 = {3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [N*WW-1:0] W3043 = {3'd3, 3'd4, 3'd0, 3'd3};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int c);
    return int'(bus.weight[c*WW +: WW]);
  endfunction

  function automatic bit elig(input int c);
    return !bus.empty[c] && (wt(c) != 0);
  endfunction

  function automatic int find(input int start);
    for (int k = 0; k < N; k++) begin
      if (elig((start + k) % N)) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst);
    exp_t x;
    int   c;
    bit   ended;
    x.gv  = (m_cur >= 0) ? 1 : 0;
    x.gid = m_gid;
    x.pop = 0;
    ended = 1'b0;
    if (rst) begin
      m_cur = -1; m_ptr = 0; m_gid = 0; m_left = 0;
    end else if (m_cur < 0) begin
      c = find(m_ptr);
      if (c >= 0) begin
        m_cur = c; m_gid = c; m_left = wt(c);
      end
    end else begin
      if (bus.empty[m_cur]) begin
        ended = 1'b1;
      end else if (bus.ready) begin
        x.pop  = 1 << m_cur;
        m_left = m_left - 1;
        ended  = (m_left == 0);
      end
      if (ended) begin
        m_ptr = (m_cur + 1) % N;
        c     = find(m_ptr);
        m_cur = c;
        if (c >= 0) begin
          m_gid = c; m_left = wt(c);
        end
      end
    end
    sb.push_back(x);
  endtask

  task automatic drive(input logic rst, input logic [N*WW-1:0] w,
                       input logic [N-1:0] e, input logic rdy);
    @(posedge clk);
    #1;
    reset      = rst;
    bus.weight = w;
    bus.empty  = e;
    bus.ready  = rdy;
    model_step(rst);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("pop", int'(bus.pop), x.pop);
        check("grant_valid", int'(bus.grant_valid), x.gv);
        check("grant_id", int'(bus.grant_id), x.gid);
        if (collect && bus.pop != '0) seen.push_back($clog2(bus.pop));
      end
    end
  end

  initial begin
    int order[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    logic [N*WW-1:0] w;
    reset      = 1'b1;
    bus.weight = W1234;
    bus.empty  = '0;
    bus.ready  = 1'b0;

    // Reset held with traffic pending.
    repeat (2) drive(1'b1, W1234, 4'b0000, 1'b1);

    // Weighted order with constant ready and all FIFOs non-empty.
    collect = 1'b1;
    repeat (21) drive(1'b0, W1234, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    collect = 1'b0;
    check("order_len", seen.size(), 20);
    for (int i = 0; i < seen.size() && i < 20; i++) check("order", seen[i], order[i % 10]);

    // Empty channels are skipped.
    drive(1'b1, W2222, 4'b0101, 1'b1);
    repeat (12) drive(1'b0, W2222, 4'b0101, 1'b1);

    // Backpressure in the middle of ch1's turn.
    drive(1'b1, W3333, 4'b0000, 1'b1);
    repeat (5) drive(1'b0, W3333, 4'b0000, 1'b1);
    repeat (5) drive(1'b0, W3333, 4'b0000, 1'b0);
    repeat (8) drive(1'b0, W3333, 4'b0000, 1'b1);

    // Forfeit on ch2 after two pops; ch1 disabled by zero weight.
    drive(1'b1, W3043, 4'b0000, 1'b1);
    repeat (6) drive(1'b0, W3043, 4'b0000, 1'b1);
    repeat (8) drive(1'b0, W3043, 4'b0100, 1'b1);

    // Reset during ch2's turn.
    drive(1'b1, W1234, 4'b0000, 1'b1);
    repeat (5) drive(1'b0, W1234, 4'b0000, 1'b1);
    drive(1'b1, W1234, 4'b0000, 1'b1);
    repeat (6) drive(1'b0, W1234, 4'b0000, 1'b1);

    // Random traffic, weight changes and occasional resets.
    w = W1234;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) w = (N*WW)'($urandom);
      drive($urandom_range(0, 199) == 0, w,
            N'($urandom_range(0, 15) & $urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
